// File: rtl/dmem_port_arbiter_if.sv
// Bundles the CPU port, the external port and the data memory port of the
// data-memory arbiter. The arbiter takes the slave view; requesters plus
// memory sit on the master side.
interface dmem_port_arbiter_if #(
   parameter int ADDR_W = 14
);
   // CPU requester (MEM stage)
   logic              cpu_req;
   logic              cpu_we;
   logic [31:0]       cpu_addr;
   logic [31:0]       cpu_wdata;
   logic [31:0]       cpu_rdata;
   logic              cpu_ack;
   logic              stall_req;

   // External requester (loader / debug)
   logic              ext_req;
   logic              ext_we;
   logic [31:0]       ext_addr;
   logic [31:0]       ext_wdata;
   logic [31:0]       ext_rdata;
   logic              ext_ack;

   // Single-port data memory
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_ack, stall_req,
      input  ext_req, ext_we, ext_addr, ext_wdata,
      output ext_rdata, ext_ack,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_ack, stall_req,
      output ext_req, ext_we, ext_addr, ext_wdata,
      input  ext_rdata, ext_ack,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Sequences the single-port data memory and shares it between the CPU MEM
// stage (default winner) and the external port, with a starvation guard
// that forces the external port through after STARVE_LIMIT lost arbitrations.
module dmem_port_arbiter #(
   parameter int ADDR_W       = 14,
   parameter int READ_LAT     = 1,
   parameter int STARVE_LIMIT = 4
) (
   input logic                clk,
   input logic                rst,
   dmem_port_arbiter_if.slave bus
);
   localparam int LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
   localparam int STV_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

   state_t           state_reg;
   logic [LAT_W-1:0] lat_cnt_reg;
   logic [STV_W-1:0] starve_cnt_reg;
   logic             grant_ext_reg;

   logic starved;
   logic ext_wins;
   logic any_req;
   logic unused_addr_bits;

   // Arbitration terms, only acted on while IDLE.
   assign starved  = (starve_cnt_reg == STV_W'(STARVE_LIMIT));
   assign ext_wins = bus.ext_req & (~bus.cpu_req | starved);
   assign any_req  = bus.cpu_req | bus.ext_req;

   // The pipeline stalls until the ack cycle itself releases it.
   assign bus.stall_req = bus.cpu_req & ~bus.cpu_ack;

   // Byte-offset and above-range address bits are deliberately ignored.
   assign unused_addr_bits = ^{bus.cpu_addr[31:ADDR_W+2], bus.cpu_addr[1:0],
                               bus.ext_addr[31:ADDR_W+2], bus.ext_addr[1:0]};

   // Access sequencer: arbitrate, issue, wait out read latency, ack.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         lat_cnt_reg    <= '0;
         starve_cnt_reg <= '0;
         grant_ext_reg  <= 1'b0;
         bus.mem_en     <= 1'b0;
         bus.mem_we     <= 1'b0;
         bus.mem_addr   <= '0;
         bus.mem_wdata  <= '0;
         bus.cpu_rdata  <= '0;
         bus.ext_rdata  <= '0;
         bus.cpu_ack    <= 1'b0;
         bus.ext_ack    <= 1'b0;
      end else begin
         // Acks are single-cycle pulses raised only on entry to DONE.
         bus.cpu_ack <= 1'b0;
         bus.ext_ack <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (ext_wins) begin
                  starve_cnt_reg <= '0;
               end else if (bus.ext_req && !starved) begin
                  starve_cnt_reg <= starve_cnt_reg + STV_W'(1);
               end
               if (any_req) begin
                  grant_ext_reg <= ext_wins;
                  bus.mem_en    <= 1'b1;
                  if (ext_wins) begin
                     bus.mem_we    <= bus.ext_we;
                     bus.mem_addr  <= bus.ext_addr[ADDR_W+1:2];
                     bus.mem_wdata <= bus.ext_wdata;
                  end else begin
                     bus.mem_we    <= bus.cpu_we;
                     bus.mem_addr  <= bus.cpu_addr[ADDR_W+1:2];
                     bus.mem_wdata <= bus.cpu_wdata;
                  end
                  state_reg <= ACCESS;
               end
            end
            ACCESS: begin
               // Memory samples the issue registers at the end of this cycle.
               bus.mem_en <= 1'b0;
               bus.mem_we <= 1'b0;
               if (bus.mem_we) begin
                  bus.cpu_ack <= ~grant_ext_reg;
                  bus.ext_ack <= grant_ext_reg;
                  state_reg   <= DONE;
               end else begin
                  lat_cnt_reg <= LAT_W'(READ_LAT - 1);
                  state_reg   <= WAIT;
               end
            end
            WAIT: begin
               if (lat_cnt_reg == '0) begin
                  if (grant_ext_reg) begin
                     bus.ext_rdata <= bus.mem_rdata;
                  end else begin
                     bus.cpu_rdata <= bus.mem_rdata;
                  end
                  bus.cpu_ack <= ~grant_ext_reg;
                  bus.ext_ack <= grant_ext_reg;
                  state_reg   <= DONE;
               end else begin
                  lat_cnt_reg <= lat_cnt_reg - LAT_W'(1);
               end
            end
            default: begin
               // DONE: requests are ignored for this one cycle.
               state_reg <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Sequences the single-port data memory behind the MEM stage and shares it between two requesters.
- Requester 0 is the CPU MEM stage, driven from the EXE/MEM register outputs. Requester 1 is the external port (UART program loader / debug).
- Generates the pipeline stall request while a CPU access is pending.
- Word-only accesses (LW/SW); byte/half handling stays in the MEM stage.

Parameters:
ADDR_W, 14, word-address width driven to memory; mem_addr = req_addr[ADDR_W+1:2]
READ_LAT, 1, memory read latency in cycles after the issue cycle; legal range >= 1
STARVE_LIMIT, 4, consecutive IDLE cycles in which the external port can lose to the CPU before it is forced to win

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous reset, active-high
cpu_req  in  1  CPU access request, level, held until cpu_ack
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  32  byte address (bits [1:0] ignored)
cpu_wdata  in  32  write data
cpu_rdata  out  32  read data, valid in the cpu_ack cycle, held until the next CPU read completes
cpu_ack  out  1  one-cycle completion pulse
stall_req  out  1  cpu_req & ~cpu_ack (combinational), to the pipeline stall logic
ext_req, ext_we, ext_addr[31:0], ext_wdata[31:0]  in  external port, same rules as the CPU port
ext_rdata  out  32  external read data, same rules as cpu_rdata
ext_ack  out  1  one-cycle completion pulse
mem_en  out  1  memory enable, registered
mem_we  out  1  memory write enable, registered
mem_addr  out  ADDR_W  word address, registered
mem_wdata  out  32  write data, registered
mem_rdata  in  32  memory read data, valid READ_LAT cycles after issue

Behaviour:
- Reset (sync): FSM = IDLE, wait counter = 0, grant = CPU. All outputs 0 (except combinational stall_req). Reset mid-access abandons the access with no ack. Outputs read 0 from the first edge with rst high.
- FSM states: IDLE, ACCESS, WAIT, DONE.
- IDLE, cycle T: arbitrate and latch the winner's we/addr/wdata into the mem_* registers (mem_en = 1 if a winner exists). Next state is ACCESS if a winner exists, else IDLE.
- ACCESS, cycle T+1: memory samples the mem_* outputs. Then:
  - write: next state DONE, mem_en/mem_we clear.
  - read: next state WAIT, mem_en clears.
- WAIT: stays READ_LAT cycles using a down-counter. On the last WAIT cycle, mem_rdata is captured into the winner's rdata register. Next state DONE.
- DONE: the winner's ack = 1 for exactly this cycle; requests are ignored. Next state IDLE.
- Timing from request:
  - write: ack at T+2, new sample possible at T+3.
  - read: ack at T+2+READ_LAT (T+3 at default).
- Requester must drop or change req in the cycle after ack. A req still high in IDLE is a new access.
- Arbitration in IDLE:
  - CPU wins by default.
  - External wins if only ext_req is high, or if both are high and wait counter == STARVE_LIMIT.
- Wait counter:
  - increments, saturating at STARVE_LIMIT, in each IDLE cycle where ext_req loses;
  - clears when external is granted;
  - holds otherwise.
- Simultaneous requests: the loser waits with no ack and keeps its req high. CPU stall_req stays 1 throughout.
- Request inputs are sampled only in IDLE. Changes to addr/wdata during ACCESS/WAIT/DONE have no effect.
- Only one ack is ever high per cycle; cpu_ack and ext_ack are never both 1.
- Unused rdata register holds its value; non-winner rdata is unchanged.

Test Plan:
- Reset then CPU write, addr 0x0000_0010, data 0xDEAD_BEEF, at T:
  - T+1: mem_en = 1, mem_we = 1, mem_addr = 4, mem_wdata = 0xDEAD_BEEF.
  - T+2: cpu_ack = 1.
  - stall_req = 1 for T..T+1.
- CPU read, addr 0x10, memory returns 0xDEAD_BEEF at READ_LAT = 1:
  - T+1: mem_en = 1, mem_we = 0.
  - T+3: cpu_ack = 1 and cpu_rdata = 0xDEAD_BEEF.
  - cpu_rdata is held after CPU req drops.
- Both requesting in the same cycle, ext read of addr 0x20: CPU granted first. Ext is granted in the first IDLE after the CPU DONE, with ext_ack 3 cycles later. cpu_ack and ext_ack are never both 1.
- Starvation: CPU issues back-to-back writes continuously, ext_req held high, STARVE_LIMIT = 4.
  - Ext loses 4 IDLE arbitrations and wins the 5th, even with cpu_req high.
  - Counter reads 0 after the ext grant.
- Reset mid-read: rst high in a WAIT cycle. Next edge: all outputs 0, FSM IDLE, no ack ever issued. A fresh read then completes normally.
- Req held high past ack: CPU keeps cpu_req = 1 after the write ack. A second write is sampled in IDLE at T+3 and acked at T+5; no ack in T+3 or T+4.
